// File: rtl/alu_arbiter_seq_pkg.sv
// Shared definitions for the ALU arbiter/sequencer: state encoding, opcodes,
// status bit positions and the opcode legality check.
package alu_arbiter_seq_pkg;

  localparam int NREQ  = 2;
  localparam int CNT_W = 8;
  localparam logic [3:0] OP_MAX = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_SUB  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_NOT  = 4'd3,
    OP_XOR  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_ROR  = 4'd11,
    OP_INC  = 4'd12,
    OP_ADD  = 4'd13
  } opcode_t;

  localparam int ST_ZERO   = 4;
  localparam int ST_SIGN   = 3;
  localparam int ST_CARRY  = 2;
  localparam int ST_OVER7  = 1;
  localparam int ST_PARITY = 0;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. On a tie the requester that did not win last
// time is granted; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Arbitrates two requesters onto the shared 4-bit ALU, one operation in flight,
// and returns the captured result over a per-requester valid/ready channel.
module alu_arbiter_seq
  import alu_arbiter_seq_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [1:0]       iReqValid,
  output logic [1:0]       oReqReady,
  input  logic [3:0]       iReqA0,
  input  logic [3:0]       iReqA1,
  input  logic [3:0]       iReqB0,
  input  logic [3:0]       iReqB1,
  input  logic [3:0]       iReqOp0,
  input  logic [3:0]       iReqOp1,
  output logic [1:0]       oRspValid,
  input  logic [1:0]       iRspReady,
  output logic [4:0]       oRspR,
  output logic [4:0]       oRspStatus,
  output logic             oRspErr,
  output logic [3:0]       oAluA,
  output logic [3:0]       oAluB,
  output logic [3:0]       oAluOp,
  input  logic [4:0]       iAluR,
  input  logic [4:0]       iAluStatus,
  output logic             oBusy,
  output logic [CNT_W-1:0] oOpCount,
  output state_t           oState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on anything but state and request valids.
  state_t           state_q, state_d;
  logic [1:0]       grant;
  logic             last_q, owner_q;
  logic [3:0]       a_q, b_q, op_q;
  logic [4:0]       r_q, status_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hs, sel_idx, sel_legal, rsp_acc;
  logic [3:0]       sel_a, sel_b, sel_op;

  rr_arb2 u_arb (
    .valid (iReqValid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    sel_idx   = grant[1];
    sel_a     = sel_idx ? iReqA1  : iReqA0;
    sel_b     = sel_idx ? iReqB1  : iReqB0;
    sel_op    = sel_idx ? iReqOp1 : iReqOp0;
    sel_legal = op_legal(sel_op);
    hs        = (state_q == ST_IDLE) && (grant != 2'b00);
    rsp_acc   = (state_q == ST_RESP) && iRspReady[owner_q];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = sel_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_acc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oReqReady = (state_q == ST_IDLE) ? grant : 2'b00;
    oRspValid = 2'b00;
    if (state_q == ST_RESP) oRspValid = owner_q ? 2'b10 : 2'b01;
    oBusy  = (state_q != ST_IDLE);
    oState = state_q;
  end

  // Operand registers load only for legal ops so the ALU inputs stay put when
  // an illegal request is bounced straight to the response phase.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      r_q      <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (hs) begin
        owner_q <= sel_idx;
        last_q  <= sel_idx;
        if (sel_legal) begin
          a_q  <= sel_a;
          b_q  <= sel_b;
          op_q <= sel_op;
        end else begin
          r_q      <= '0;
          status_q <= '0;
          err_q    <= 1'b1;
        end
      end
      if (state_q == ST_EXEC) begin
        r_q      <= iAluR;
        status_q <= iAluStatus;
        err_q    <= 1'b0;
      end
      if (rsp_acc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign oAluA      = a_q;
  assign oAluB      = b_q;
  assign oAluOp     = op_q;
  assign oRspR      = r_q;
  assign oRspStatus = status_q;
  assign oRspErr    = err_q;
  assign oOpCount   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: stub ALU, transaction-level model checked every
// falling edge, directed scenarios with literal expectations, random traffic.
module tb_alu_arbiter_seq;
  import alu_arbiter_seq_pkg::*;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic [1:0]       iReqValid = '0, oReqReady;
  logic [3:0]       iReqA0 = '0, iReqA1 = '0, iReqB0 = '0, iReqB1 = '0;
  logic [3:0]       iReqOp0 = '0, iReqOp1 = '0;
  logic [1:0]       oRspValid, iRspReady = '0;
  logic [4:0]       oRspR, oRspStatus, iAluR, iAluStatus;
  logic             oRspErr, oBusy;
  logic [3:0]       oAluA, oAluB, oAluOp;
  logic [CNT_W-1:0] oOpCount;
  state_t           oState;

  int total = 0;
  int bad   = 0;

  alu_arbiter_seq dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqA0(iReqA0), .iReqA1(iReqA1), .iReqB0(iReqB0), .iReqB1(iReqB1),
    .iReqOp0(iReqOp0), .iReqOp1(iReqOp1), .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspR(oRspR), .oRspStatus(oRspStatus), .oRspErr(oRspErr), .oAluA(oAluA),
    .oAluB(oAluB), .oAluOp(oAluOp), .iAluR(iAluR), .iAluStatus(iAluStatus),
    .oBusy(oBusy), .oOpCount(oOpCount), .oState(oState)
  );

  always #5 iClk = ~iClk;

  // Stub ALU: returns {status, R}
  function automatic logic [9:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    logic [4:0] full;
    logic [3:0] r;
    logic       c;
    full = '0; r = '0; c = 1'b0;
    case (op)
      4'd0:  begin full = {1'b0, a} - {1'b0, b}; r = full[3:0]; c = full[4]; end
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = ~a;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a & b);
      4'd6:  r = ~(a | b);
      4'd7:  r = ~(a ^ b);
      4'd8:  begin r = {a[2:0], 1'b0}; c = a[3]; end
      4'd9:  begin r = {1'b0, a[3:1]}; c = a[0]; end
      4'd10: r = {a[2:0], a[3]};
      4'd11: r = {a[0], a[3:1]};
      4'd12: begin full = {1'b0, a} + 5'd1; r = full[3:0]; c = full[4]; end
      4'd13: begin full = {1'b0, a} + {1'b0, b}; r = full[3:0]; c = full[4]; end
      default: r = '0;
    endcase
    return {(r == 4'd0), r[3], c, (r > 4'd7), ~^r, 1'b0, r};
  endfunction

  assign {iAluStatus, iAluR} = alu_fn(oAluA, oAluB, oAluOp);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Arbitration rule: a lone requester wins; on a tie the one not served last.
  function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Transaction model: an op is in flight for 'm_age' cycles after its handshake.
  bit               m_busy = 0;
  int               m_age = 0;
  logic             m_owner = 0, m_last = 1;
  logic [3:0]       m_a, m_b, m_op;
  logic [3:0]       m_alu_a = '0, m_alu_b = '0, m_alu_op = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [1:0]       e_ready, e_rspv;
  logic [9:0]       e_res;
  bit               e_rsp, e_legal;

  always @(negedge iClk) begin
    if (!iRst_n) begin
      m_busy = 0; m_age = 0; m_last = 1; m_cnt = '0;
      m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
      chk("rst_ready", oReqReady, 0);
      chk("rst_rspv", oRspValid, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_cnt", oOpCount, 0);
      chk("rst_alu", {oAluA, oAluB, oAluOp}, 0);
      chk("rst_rsp", {oRspR, oRspStatus, oRspErr}, 0);
    end else begin
      e_ready = 2'b00; e_rspv = 2'b00; e_rsp = 0; e_legal = 0;
      if (!m_busy) e_ready = pick(iReqValid, m_last);
      else begin
        e_legal = (m_op <= 4'd13);
        e_rsp = (m_age >= (e_legal ? 2 : 1));
        if (e_rsp) e_rspv[m_owner] = 1'b1;
      end
      chk("m_ready", oReqReady, e_ready);
      chk("m_rspv", oRspValid, e_rspv);
      chk("m_busy", oBusy, m_busy);
      chk("m_cnt", oOpCount, m_cnt);
      chk("m_alu", {oAluA, oAluB, oAluOp}, {m_alu_a, m_alu_b, m_alu_op});
      if (e_rsp) begin
        e_res = e_legal ? alu_fn(m_a, m_b, m_op) : 10'd0;
        chk("m_r", oRspR, e_res[4:0]);
        chk("m_status", oRspStatus, e_res[9:5]);
        chk("m_err", oRspErr, !e_legal);
      end
      if (!m_busy) begin
        if (e_ready != 2'b00) begin
          m_busy = 1; m_age = 1; m_owner = e_ready[1]; m_last = e_ready[1];
          m_a  = m_owner ? iReqA1  : iReqA0;
          m_b  = m_owner ? iReqB1  : iReqB0;
          m_op = m_owner ? iReqOp1 : iReqOp0;
          if (m_op <= 4'd13) begin m_alu_a = m_a; m_alu_b = m_b; m_alu_op = m_op; end
        end
      end else if (e_rsp && iRspReady[m_owner]) begin
        m_busy = 0; m_cnt = m_cnt + 1'b1;
      end else m_age++;
    end
  end

  task automatic set_req(input int req, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op);
    if (req == 0) begin iReqA0 = a; iReqB0 = b; iReqOp0 = op; end
    else          begin iReqA1 = a; iReqB1 = b; iReqOp1 = op; end
  endtask

  task automatic do_reset();
    @(negedge iClk); #1;
    iRst_n = 0; iReqValid = '0; iRspReady = '0;
    @(negedge iClk); #1;
    iRst_n = 1;
  endtask

  // Issue one request, check handshake and response latency/data; returns at the
  // falling edge where the response is first visible.
  task automatic issue_chk(input int req, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input int lat, input logic [4:0] er,
                           input logic [4:0] es, input logic ee, input string nm);
    int  k;
    bit  got;
    @(posedge iClk); #1;
    set_req(req, a, b, op);
    iReqValid[req] = 1'b1;
    got = 0; k = 0;
    while (!got && k < 20) begin
      @(negedge iClk); k++;
      if (oReqReady[req]) got = 1;
    end
    chk({nm, "_hs"}, got, 1);
    @(posedge iClk); #1;
    iReqValid[req] = 1'b0;
    got = 0; k = 0;
    while (!got && k < 20) begin
      @(negedge iClk); k++;
      if (oRspValid != 2'b00) got = 1;
    end
    chk({nm, "_seen"}, got, 1);
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_rspv"}, oRspValid, (req == 0) ? 2'b01 : 2'b10);
    chk({nm, "_r"}, oRspR, er);
    chk({nm, "_st"}, oRspStatus, es);
    chk({nm, "_err"}, oRspErr, ee);
  endtask

  // Hold both requesters valid until each is granted; record response order.
  logic [1:0] ord_q[$];
  logic [4:0] r_q[$];
  logic [4:0] s_q[$];

  task automatic tie_run();
    int k;
    bit d0, d1;
    ord_q.delete(); r_q.delete(); s_q.delete();
    @(posedge iClk); #1;
    set_req(0, 4'd1, 4'd2, 4'd13);
    set_req(1, 4'd5, 4'd1, 4'd4);
    iRspReady = 2'b11;
    iReqValid = 2'b11;
    d0 = 0; d1 = 0; k = 0;
    while (ord_q.size() < 2 && k < 30) begin
      @(negedge iClk); k++;
      if (oReqReady[0]) d0 = 1;
      if (oReqReady[1]) d1 = 1;
      if (oRspValid != 2'b00) begin
        ord_q.push_back(oRspValid); r_q.push_back(oRspR); s_q.push_back(oRspStatus);
      end
      @(posedge iClk); #1;
      if (d0) iReqValid[0] = 1'b0;
      if (d1) iReqValid[1] = 1'b0;
    end
    iReqValid = 2'b00;
    chk("tie_count", ord_q.size(), 2);
    while (ord_q.size() < 2) begin
      ord_q.push_back(2'b00); r_q.push_back('0); s_q.push_back('0);
    end
  endtask

  initial begin
    int k;
    bit got;
    repeat (2) @(negedge iClk);
    #1 iRst_n = 1;

    iRspReady = 2'b11;
    issue_chk(0, 4'd9, 4'd8, 4'd13, 2, 5'b00001, 5'b00100, 1'b0, "add98");
    @(posedge iClk); #1;
    @(negedge iClk);
    chk("add98_cnt", oOpCount, 1);

    issue_chk(1, 4'd3, 4'd3, 4'd0, 2, 5'b00000, 5'b10001, 1'b0, "sub33");
    @(posedge iClk); #1;

    issue_chk(0, 4'd2, 4'd7, 4'd14, 1, 5'b00000, 5'b00000, 1'b1, "illegal");
    chk("illegal_alu", {oAluA, oAluB, oAluOp}, {4'd3, 4'd3, 4'd0});
    @(posedge iClk); #1;
    @(negedge iClk);
    chk("illegal_cnt", oOpCount, 3);

    do_reset();
    tie_run();
    chk("tie1_first", ord_q[0], 2'b01);
    chk("tie1_first_r", r_q[0], 5'd3);
    chk("tie1_second", ord_q[1], 2'b10);
    chk("tie1_second_r", r_q[1], 5'd4);
    chk("tie1_second_st", s_q[1], 5'b00000);
    tie_run();
    chk("tie2_first", ord_q[0], 2'b01);
    chk("tie2_second", ord_q[1], 2'b10);

    // Response held off: data stable, pending requester not accepted.
    @(posedge iClk); #1;
    iRspReady = 2'b00;
    issue_chk(0, 4'd6, 4'd7, 4'd13, 2, 5'b01101, 5'b01010, 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge iClk); #1;
      if (i == 0) begin set_req(1, 4'd4, 4'd4, 4'd1); iReqValid[1] = 1'b1; end
      @(negedge iClk);
      chk("hold_rspv", oRspValid, 2'b01);
      chk("hold_r", oRspR, 5'b01101);
      chk("hold_st", oRspStatus, 5'b01010);
      chk("hold_ready", oReqReady, 2'b00);
    end
    @(posedge iClk); #1;
    iRspReady = 2'b11;
    got = 0; k = 0;
    while (!got && k < 10) begin
      @(negedge iClk); k++;
      if (oReqReady[1]) got = 1;
    end
    chk("hold_req1_granted", got, 1);
    @(posedge iClk); #1;
    iReqValid = 2'b00;
    repeat (4) @(posedge iClk);
    #1;

    // Reset in the middle of execution.
    set_req(0, 4'd2, 4'd2, 4'd13);
    iReqValid[0] = 1'b1;
    got = 0; k = 0;
    while (!got && k < 10) begin
      @(negedge iClk); k++;
      if (oReqReady[0]) got = 1;
    end
    chk("mid_hs", got, 1);
    @(posedge iClk); #2;
    iRst_n = 0;
    #1;
    chk("mid_busy", oBusy, 0);
    chk("mid_rspv", oRspValid, 0);
    chk("mid_cnt", oOpCount, 0);
    chk("mid_alu", {oAluA, oAluB, oAluOp}, 0);
    iReqValid = 2'b00;
    @(negedge iClk); #1;
    iRst_n = 1;
    issue_chk(0, 4'd4, 4'd5, 4'd13, 2, 5'b01001, 5'b01011, 1'b0, "post_rst");
    @(posedge iClk); #1;
    @(negedge iClk);
    chk("post_rst_cnt", oOpCount, 1);

    // Random traffic; the model checks every cycle and counts through a wrap.
    for (int i = 0; i < 1500; i++) begin
      @(posedge iClk); #1;
      iReqValid = 2'($urandom_range(0, 3));
      set_req(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      set_req(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      iRspReady = 2'($urandom_range(0, 3));
    end
    @(posedge iClk); #1;
    iReqValid = 2'b00;
    iRspReady = 2'b11;
    repeat (6) @(posedge iClk);
    @(negedge iClk);
    chk("drain_idle", oBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
Two-requester arbiter and sequencer for the shared 4-bit arithmetic/logic unit. Each requester issues an operation (A, B, opcode) over a valid/ready handshake. The block grants requesters round-robin, drives the registered operands into the combinational ALU, captures R and Status, and returns them over a per-requester valid/ready response channel. Only one operation is in flight at a time. The block sits between the ALU and its clients (control FSM, test front-end).

Parameters:
NREQ, 2, number of requesters (fixed at 2 for this revision)
OP_MAX, 13, highest legal opcode; opcodes above it are rejected with error
CNT_W, 8, width of the completed-operation counter

Ports:
iClk  in  1  clock
iRst_n  in  1  reset; asynchronous and active-low
iReqValid  in  2  per-requester request valid
oReqReady  out  2  per-requester request accepted (one-hot or zero)
iReqA0 / iReqA1  in  4  operand A per requester
iReqB0 / iReqB1  in  4  operand B per requester
iReqOp0 / iReqOp1  in  4  opcode per requester
oRspValid  out  2  per-requester response valid (one-hot or zero)
iRspReady  in  2  per-requester response accept
oRspR  out  5  captured ALU result (R[4] always 0)
oRspStatus  out  5  captured ALU status {zero, sign, carry, over7, parity}
oRspErr  out  1  illegal opcode flag for the current response
oAluA / oAluB  out  4  operands to the ALU
oAluOp  out  4  opcode to the ALU
iAluR  in  5  ALU result
iAluStatus  in  5  ALU status
oBusy  out  1  high whenever the state is not IDLE
oOpCount  out  CNT_W  completed responses, wraps at 2^CNT_W

Behaviour:
- Reset values: state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if only one iReqValid bit is set, grant that requester. If both are set, grant the requester that is not last_grant.
  - oReqReady[g] is high combinationally in IDLE for the granted requester only.
  - On handshake: latch A, B, Op into the operand registers, latch owner=g, update last_grant=g.
  - Legal opcode (Op<=OP_MAX): go to EXEC. Illegal opcode: go to RESP with err=1, R=0, Status=0.
- EXEC: oAluA/B/Op come from the operand registers (stable the whole cycle). At the cycle end, capture iAluR/iAluStatus into the response registers, err=0, then go to RESP.
- RESP:
  - oRspValid[owner]=1. Response data holds stable until iRspReady[owner]=1.
  - On acceptance: increment oOpCount and go to IDLE.
  - iRspReady on the non-owner bit is ignored.
- Latency: request handshake at cycle T; response valid at T+2 for a legal op, T+1 for an illegal op. Minimum issue interval is 3 cycles.
- oAluA/B/Op hold their last values outside EXEC (no toggling in IDLE).
- A request withdrawn before handshake is legal; arbitration is re-evaluated every IDLE cycle.
- A new iReqValid during EXEC/RESP is not accepted (oReqReady=0). It waits.
- Reset asserted mid-operation: immediate return to IDLE. The in-flight response is dropped, and the counter and last_grant are reset.
- oOpCount wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, EXEC=1, RESP=2)
  - opcode constants (SUB=0 .. ADD=13)
  - OP_MAX
  - Status bit indices (ZERO=4, SIGN=3, CARRY=2, OVER7=1, PARITY=0)
- Sub-module rr_arb2: 2-input round-robin grant from valids and last_grant. It is purely combinational and reused by the future register-file port arbiter.

Test Plan:
- Req0 A=9 B=8 Op=13, iRspReady0=1 -> handshake T, oRspValid=2'b01 at T+2, R=5'b00001, Status=5'b00100, Err=0, oOpCount=1.
- Req1 A=3 B=3 Op=0 -> R=0, Status=5'b10001, oRspValid=2'b10 at T+2.
- Both valid from reset (A0=1,B0=2,Op0=13; A1=5,B1=1,Op1=4) -> req0 served first (R=3), then req1 (R=4, Status=5'b00000). A second tie goes to req0 again only after req1 has been served.
- Req0 Op=14 -> oRspValid=2'b01 at T+1, Err=1, R=0, Status=0; ALU outputs unchanged; counter increments on accept.
- iRspReady0 held low 5 cycles -> oRspValid, R, Status stable all 5 cycles; oReqReady=0 to a pending req1 until acceptance.
- iRst_n pulsed low during EXEC -> outputs 0 asynchronously, state IDLE. The next req0 completes normally with oOpCount=1.
